// File: rtl/verisparse_pkg.sv
// verisparse_pkg: command and sequencer state types shared across the verisparse engine
package verisparse_pkg;
    localparam int DICT_CMD_W = 2;
    typedef enum logic [DICT_CMD_W-1:0] {
        NOP                    = 2'd0,
        LOAD_SENSING_MATRIX    = 2'd1,
        COMPUTE_INNER_PRODUCTS = 2'd2
    } dict_cmd_t;
    typedef enum logic [3:0] {
        IDLE,
        LOAD_START,
        LOAD_STREAM,
        WAIT_RES,
        SWEEP_START,
        SWEEP_RUN,
        MAX_WAIT,
        RECORD,
        FINISH
    } seq_state_t;
endpackage

// File: rtl/vs_watchdog_counter.sv
// vs_watchdog_counter: counts cycles spent in a watched state and flags the LIMIT-th one
module vs_watchdog_counter #(
    parameter int LIMIT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] count;
    logic [W-1:0] spent;
    assign spent   = clear ? '0 : count;
    assign expired = enable && spent == W'(LIMIT - 1);
    // Advance only while enabled so unwatched states leave the counter at zero
    always_ff @(posedge clock) begin
        if (reset) count <= '0;
        else count <= enable ? spent + 1'b1 : '0;
    end
endmodule

// File: rtl/vs_sweep_sequencer.sv
// vs_sweep_sequencer: one sensing-matrix load followed by K sweep/max rounds, recording each winner
module vs_sweep_sequencer
    import verisparse_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLUMNS        = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic [3:0]  num_atoms,
    input  logic        residual_ready,
    input  logic        proc_done,
    input  logic        max_done,
    input  logic [7:0]  max_location,
    output dict_cmd_t   command,
    output logic        proc_start,
    output logic        proc_read_select,
    output logic [15:0] phi_read_addr,
    output logic        atom_valid,
    output logic [7:0]  atom_index,
    output logic [3:0]  atom_count,
    output logic        busy,
    output logic        done,
    output logic        timeout
);
    localparam logic [15:0] ADDR_MAX  = 16'(ROWS * COLUMNS - 1);
    localparam logic [8:0]  COL_LIMIT = 9'(COLUMNS);
    seq_state_t state;
    seq_state_t prev_state;
    logic [3:0] k_target;
    logic       watched;
    logic       expired;
    assign watched = state inside {LOAD_STREAM, SWEEP_RUN, MAX_WAIT};
    vs_watchdog_counter #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != prev_state),
        .enable  (watched),
        .expired (expired)
    );
    // Sequencer: every output is assigned on the transition into its state so it comes from a flop
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            prev_state       <= IDLE;
            k_target         <= '0;
            command          <= NOP;
            proc_start       <= 1'b0;
            proc_read_select <= 1'b0;
            phi_read_addr    <= '0;
            atom_valid       <= 1'b0;
            atom_index       <= '0;
            atom_count       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            timeout          <= 1'b0;
        end else begin
            prev_state <= state;
            proc_start <= 1'b0;
            atom_valid <= 1'b0;
            done       <= 1'b0;
            if (expired) begin
                state            <= IDLE;
                command          <= NOP;
                proc_read_select <= 1'b0;
                busy             <= 1'b0;
                timeout          <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (go) begin
                        timeout <= 1'b0;
                        if (num_atoms == 4'd0) done <= 1'b1;
                        else begin
                            state            <= LOAD_START;
                            k_target         <= num_atoms;
                            atom_count       <= '0;
                            busy             <= 1'b1;
                            command          <= LOAD_SENSING_MATRIX;
                            proc_read_select <= 1'b1;
                            phi_read_addr    <= '0;
                            proc_start       <= 1'b1;
                        end
                    end
                    LOAD_START: state <= LOAD_STREAM;
                    LOAD_STREAM: if (proc_done) begin
                        state            <= WAIT_RES;
                        proc_read_select <= 1'b0;
                    end else if (phi_read_addr != ADDR_MAX) phi_read_addr <= phi_read_addr + 16'd1;
                    WAIT_RES: if (residual_ready) begin
                        state      <= SWEEP_START;
                        command    <= COMPUTE_INNER_PRODUCTS;
                        proc_start <= 1'b1;
                    end
                    SWEEP_START: state <= SWEEP_RUN;
                    SWEEP_RUN, MAX_WAIT: if (max_done && (proc_done || state == MAX_WAIT)) begin
                        state      <= RECORD;
                        atom_index <= max_location;
                        atom_valid <= 1'b1;
                        atom_count <= atom_count + 4'd1;
                        if ({1'b0, max_location} >= COL_LIMIT) timeout <= 1'b1;
                    end else if (proc_done) state <= MAX_WAIT;
                    RECORD: if (atom_count == k_target) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else state <= WAIT_RES;
                    FINISH: begin
                        state   <= IDLE;
                        command <= NOP;
                        busy    <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vs_sweep_sequencer.sv
// tb_vs_sweep_sequencer: scenario table, directed corner cases and randomized runs against a behavioural model
module tb_vs_sweep_sequencer;
    import verisparse_pkg::*;
    typedef struct {
        int k; int l; int s; int m; int g;
        int v0; int v1; int v2;
        int exp_done; int exp_to;
    } vec_t;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [3:0]  num_atoms = 4'd0;
    logic        residual_ready = 1'b1;
    logic        proc_done = 1'b0;
    logic        max_done = 1'b0;
    logic [7:0]  max_location = 8'd0;
    dict_cmd_t   command;
    logic        proc_start, proc_read_select, atom_valid, busy, done, timeout;
    logic [15:0] phi_read_addr;
    logic [7:0]  atom_index;
    logic [3:0]  atom_count;
    int n_cmp = 0;
    int n_bad = 0;
    int maxq[$];
    int got[$];
    int n_start, n_load, n_done, n_consec, n_busy, max_addr;
    int pcnt, mcnt, rwait, pend;
    int ll, sl, ml, gap;
    bit loading, prev_ps, chaos;

    vs_sweep_sequencer #(.ROWS(4), .COLUMNS(8), .TIMEOUT_CYCLES(64)) dut (
        .clock            (clock),
        .reset            (reset),
        .go               (go),
        .num_atoms        (num_atoms),
        .residual_ready   (residual_ready),
        .proc_done        (proc_done),
        .max_done         (max_done),
        .max_location     (max_location),
        .command          (command),
        .proc_start       (proc_start),
        .proc_read_select (proc_read_select),
        .phi_read_addr    (phi_read_addr),
        .atom_valid       (atom_valid),
        .atom_index       (atom_index),
        .atom_count       (atom_count),
        .busy             (busy),
        .done             (done),
        .timeout          (timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL global_time_limit: got still running, expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " command"}, int'(command), 0);
        chk({tag, " proc_start"}, int'(proc_start), 0);
        chk({tag, " proc_read_select"}, int'(proc_read_select), 0);
        chk({tag, " phi_read_addr"}, int'(phi_read_addr), 0);
        chk({tag, " atom_valid"}, int'(atom_valid), 0);
        chk({tag, " atom_index"}, int'(atom_index), 0);
        chk({tag, " atom_count"}, int'(atom_count), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " timeout"}, int'(timeout), 0);
    endtask

    // One clock: sample outputs after the edge, update monitors, then drive the stub processor/max unit
    task automatic cycle();
        int v;
        @(posedge clock);
        #1;
        if (proc_start && prev_ps) n_consec++;
        prev_ps = proc_start;
        if (proc_start) n_start++;
        if (proc_start && command == LOAD_SENSING_MATRIX) n_load++;
        if (int'(phi_read_addr) > max_addr) max_addr = int'(phi_read_addr);
        if (atom_valid) got.push_back(int'(atom_index));
        if (done) n_done++;
        if (busy) n_busy++;
        go = (chaos && busy) ? 1'($urandom) : 1'b0;
        if (chaos && busy) num_atoms = 4'($urandom);
        proc_done = 1'b0;
        max_done = 1'b0;
        if (rwait > 0) rwait--;
        if (atom_valid) rwait = gap;
        residual_ready = (rwait == 0);
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                max_done = 1'b1;
                max_location = 8'(pend);
            end
        end
        if (pcnt > 0) begin
            pcnt--;
            if (pcnt == 0) begin
                proc_done = 1'b1;
                if (!loading) begin
                    v = 0;
                    if (maxq.size() > 0) v = maxq.pop_front();
                    if (v < 0) mcnt = -1;
                    else if (ml == 0) begin
                        max_done = 1'b1;
                        max_location = 8'(v);
                    end else begin
                        mcnt = ml;
                        pend = v;
                    end
                end
            end
        end
        if (proc_start) begin
            loading = (command == LOAD_SENSING_MATRIX);
            pcnt = loading ? ll : sl;
        end
    endtask

    // A whole run: vals are the max unit's answers per sweep, a negative one meaning it never answers
    task automatic run_case(input string tag, input int k, input int l, input int s, input int m, input int g,
                            input int vals[$], input int exp_done, input int exp_to);
        int rec[$];
        int t;
        for (int i = 0; i < k && i < vals.size(); i++) begin
            if (vals[i] < 0) break;
            rec.push_back(vals[i]);
        end
        maxq = vals;
        got.delete();
        n_start = 0; n_load = 0; n_done = 0; n_consec = 0; max_addr = 0;
        pcnt = 0; mcnt = 0; rwait = 0; residual_ready = 1'b1;
        ll = l; sl = s; ml = m; gap = g; chaos = 1'b1;
        num_atoms = 4'(k);
        go = 1'b1;
        cycle();
        chk({tag, " busy_at_start"}, int'(busy), 1);
        chk({tag, " timeout_cleared"}, int'(timeout), 0);
        t = 0;
        while (busy && t < 20000) begin
            cycle();
            t++;
        end
        chk({tag, " finished_in_bound"}, int'(t < 20000), 1);
        repeat (2) cycle();
        chk({tag, " atoms"}, got.size(), rec.size());
        for (int i = 0; i < rec.size() && i < got.size(); i++) chk($sformatf("%s atom%0d", tag, i), got[i], rec[i]);
        chk({tag, " atom_count"}, int'(atom_count), rec.size());
        chk({tag, " done_pulses"}, n_done, exp_done);
        chk({tag, " timeout"}, int'(timeout), exp_to);
        chk({tag, " loads"}, n_load, 1);
        chk({tag, " proc_starts"}, n_start, rec.size() + 1 + (exp_done != 0 ? 0 : 1));
        chk({tag, " consecutive_starts"}, n_consec, 0);
        chk({tag, " max_phi_addr"}, max_addr, (l - 1 < 31) ? l - 1 : 31);
        chk({tag, " command_idle"}, int'(command), int'(NOP));
    endtask

    initial begin
        vec_t tbl[6];
        int q[$];
        int t;
        int k, exp_to, exp_done;
        tbl[0] = '{1, 32, 5, 3,   0, 4, 0, 0, 1, 0};
        tbl[1] = '{3, 10, 4, 2,   0, 2, 5, 7, 1, 0};
        tbl[2] = '{2,  6, 3, 0,   1, 1, 3, 0, 1, 0};
        tbl[3] = '{2,  8, 2, 4,   0, 9, 6, 0, 1, 1};
        tbl[4] = '{1, 40, 6, 1,   0, 0, 0, 0, 1, 0};
        tbl[5] = '{2, 12, 3, 2, 500, 6, 3, 0, 1, 0};
        chaos = 1'b0;
        pcnt = 0; mcnt = 0; rwait = 0;
        repeat (3) cycle();
        chk_zero("reset");
        reset = 1'b0;
        cycle();
        foreach (tbl[i]) begin
            q.delete();
            q.push_back(tbl[i].v0);
            q.push_back(tbl[i].v1);
            q.push_back(tbl[i].v2);
            run_case($sformatf("vec%0d", i), tbl[i].k, tbl[i].l, tbl[i].s, tbl[i].m, tbl[i].g,
                     q, tbl[i].exp_done, tbl[i].exp_to);
        end
        chaos = 1'b0; ll = -1; pcnt = 0; mcnt = 0; n_done = 0; max_addr = 0;
        num_atoms = 4'd2;
        go = 1'b1;
        cycle();
        chk("wd proc_start", int'(proc_start), 1);
        t = 0;
        while (!timeout && t < 200) begin
            cycle();
            t++;
        end
        chk("wd latency", t, 65);
        chk("wd busy", int'(busy), 0);
        chk("wd max_phi_addr", max_addr, 31);
        repeat (3) cycle();
        chk("wd no_done", n_done, 0);
        chk("wd sticky", int'(timeout), 1);
        q.delete();
        q.push_back(7);
        run_case("after_wd", 1, 20, 3, 2, 0, q, 1, 0);
        chaos = 1'b0; ll = 10; sl = 5; ml = 3; gap = 0; rwait = 0; residual_ready = 1'b1;
        pcnt = 0; mcnt = 0; n_done = 0;
        got.delete();
        maxq.delete();
        maxq.push_back(-1);
        num_atoms = 4'd2;
        go = 1'b1;
        repeat (40) cycle();
        chk("maxwait busy", int'(busy), 1);
        chk("maxwait command", int'(command), int'(COMPUTE_INNER_PRODUCTS));
        chk("maxwait atoms", got.size(), 0);
        reset = 1'b1;
        cycle();
        chk_zero("reset_mid");
        reset = 1'b0;
        pcnt = 0; mcnt = 0;
        repeat (3) cycle();
        chk("reset_mid no_done", n_done, 0);
        n_done = 0; n_busy = 0;
        num_atoms = 4'd0;
        go = 1'b1;
        cycle();
        chk("k0 done", int'(done), 1);
        cycle();
        chk("k0 done_pulse_end", int'(done), 0);
        repeat (2) cycle();
        chk("k0 done_count", n_done, 1);
        chk("k0 busy_count", n_busy, 0);
        for (int r = 0; r < 12; r++) begin
            q.delete();
            k = int'($urandom_range(1, 6));
            for (int i = 0; i < k; i++) q.push_back(int'($urandom_range(0, 11)));
            if ($urandom_range(0, 3) == 0) q[$urandom_range(0, k - 1)] = -1;
            exp_to = 0;
            exp_done = 1;
            for (int i = 0; i < k; i++) begin
                if (q[i] < 0) begin
                    exp_done = 0;
                    exp_to = 1;
                    break;
                end
                if (q[i] >= 8) exp_to = 1;
            end
            run_case($sformatf("rnd%0d", r), k, int'($urandom_range(1, 50)), int'($urandom_range(1, 40)),
                     int'($urandom_range(0, 40)), int'($urandom_range(0, 20)), q, exp_done, exp_to);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vs_sweep_sequencer.md
VS_SWEEP_SEQUENCER -- requirements
Module: vs_sweep_sequencer

Interface
REQ-001 SHALL have parameters: ROWS, default 4, measurement rows; COLUMNS, default 8, dictionary atoms; TIMEOUT_CYCLES, default 1024, max cycles waiting on any done input.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports, in this order:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- go  in  1  start a run, sampled in IDLE only
- num_atoms  in  4  sweeps to perform (K)
- residual_ready  in  1  host level: residual RAM is valid for the next sweep
- proc_done  in  1  sensing matrix processor done
- max_done  in  1  max identifier batch done
- max_location  in  8  winning column from the max identifier
- command  out  DICT_CMD_W  processor command (package enum)
- proc_start  out  1  one-cycle start to the processor
- proc_read_select  out  1  1 = phi RAM, 0 = residual RAM
- phi_read_addr  out  16  phi RAM read address
- atom_valid  out  1  one-cycle strobe; atom_index is valid
- atom_index  out  8  selected column
- atom_count  out  4  sweeps completed in the current run
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle run-complete pulse
- timeout  out  1  sticky error; cleared by reset or an accepted go

Function
REQ-004 SHALL implement the states IDLE, LOAD_START, LOAD_STREAM, WAIT_RES, SWEEP_START, SWEEP_RUN, MAX_WAIT, RECORD and FINISH.
REQ-005 IDLE: on go=1 with num_atoms>0, SHALL go to LOAD_START, clear atom_count and clear timeout.
REQ-006 IDLE: on go=1 with num_atoms=0, SHALL pulse done on the next cycle and stay in IDLE.
REQ-007 LOAD_START: SHALL drive command=LOAD_SENSING_MATRIX, proc_read_select=1, phi_read_addr=0, proc_start=1 for exactly one cycle, then go to LOAD_STREAM.
REQ-008 LOAD_STREAM: phi_read_addr SHALL increment by 1 each cycle while proc_done=0.
REQ-009 LOAD_STREAM: phi_read_addr SHALL saturate at ROWS*COLUMNS-1.
REQ-010 LOAD_STREAM: on proc_done=1, SHALL go to WAIT_RES.
REQ-011 WAIT_RES: SHALL drive proc_read_select=0 and wait for residual_ready=1, then go to SWEEP_START; this wait is not subject to timeout.
REQ-012 SWEEP_START: SHALL drive command=COMPUTE_INNER_PRODUCTS and proc_start=1 for one cycle, then go to SWEEP_RUN.
REQ-013 SWEEP_RUN SHALL go to MAX_WAIT on proc_done=1.
REQ-014 MAX_WAIT SHALL go to RECORD on max_done=1.
REQ-015 If proc_done and max_done are both high in the same SWEEP_RUN cycle, SHALL go directly to RECORD.
REQ-016 RECORD: SHALL register max_location into atom_index, assert atom_valid for one cycle and increment atom_count.
REQ-017 RECORD: if atom_count after the increment equals num_atoms latched at go, SHALL go to FINISH; otherwise SHALL go to WAIT_RES (matrix not reloaded).
REQ-018 FINISH: SHALL pulse done for one cycle and go to IDLE.
REQ-019 Watchdog: a counter SHALL clear on every state change and count cycles spent in LOAD_STREAM, SWEEP_RUN and MAX_WAIT.
REQ-020 On count=TIMEOUT_CYCLES, SHALL set timeout, go to IDLE and not assert done.
REQ-021 num_atoms SHALL be latched at go; changes mid-run have no effect.
REQ-022 go while busy SHALL be ignored.
REQ-023 proc_start SHALL never be high on two consecutive cycles.
REQ-024 max_location values >= COLUMNS SHALL still be recorded and SHALL set timeout (error).
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 On reset=1 at a clock edge, the state SHALL be IDLE.
REQ-027 On reset, all outputs SHALL be 0, including command=NOP (encoding 0), atom_index, atom_count and the watchdog.
REQ-028 Reset SHALL abort any run mid-operation without asserting done.

Structure
REQ-029 The command enum, DICT_CMD_W and the sequencer state enum SHALL live in the shared verisparse package.
REQ-030 The watchdog SHALL be a sub-module, vs_watchdog_counter (clear, enable, expired).

Verification
REQ-031 K=1, stub processor asserts proc_done 32 cycles after load start, max stub returns 4 -> exactly one atom_valid with atom_index=4, atom_count=1, then done.
REQ-032 K=3, max stub returns 2, 5, 7 -> three atom_valid strobes in that order; exactly one LOAD_START; proc_start count = 4.
REQ-033 residual_ready held low for 500 cycles between sweeps with TIMEOUT_CYCLES=64 -> no timeout; sweep proceeds once residual_ready rises.
REQ-034 proc_done never asserted during load, TIMEOUT_CYCLES=64 -> timeout=1 after 64 LOAD_STREAM cycles, IDLE, no done; next go clears timeout.
REQ-035 reset asserted in MAX_WAIT -> all outputs 0 the next cycle; go=1 with num_atoms=0 -> single done pulse, busy stays 0.
REQ-036 Check across all scenarios: phi_read_addr never exceeds 31 for ROWS=4, COLUMNS=8, even with proc_done held off for 40 cycles.
